// File: rtl/cp0_pkg.sv
// Shared definitions for the CP0 exception/interrupt sequencer:
// cause codes, Status bit positions and the sequencer state encoding.
package cp0_pkg;

    localparam logic [4:0] CAUSE_INT     = 5'b00000;
    localparam logic [4:0] CAUSE_SYSCALL = 5'b01000;
    localparam logic [4:0] CAUSE_BREAK   = 5'b01001;
    localparam logic [4:0] CAUSE_TEQ     = 5'b01101;

    localparam int ST_IE  = 0;
    localparam int ST_SYS = 1;
    localparam int ST_BRK = 2;
    localparam int ST_TEQ = 3;
    localparam int ST_INT = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        EXC_ENTER = 3'd1,
        EXC_REDIR = 3'd2,
        RET_ENTER = 3'd3,
        RET_REDIR = 3'd4
    } state_t;

endpackage

// File: rtl/cp0_irq_sync.sv
// Synchroniser for the asynchronous interrupt line; emits a single
// cycle pulse on each synchronised rising edge.
module cp0_irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic intr,
    output logic pulse
);

    logic [STAGES-1:0] chain;
    logic              prev;

    // Flop chain into the clock domain, plus one flop for edge detection
    always_ff @(posedge clk) begin
        if (!rst) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], intr};
            prev  <= chain[STAGES-1];
        end
    end

    assign pulse = chain[STAGES-1] & ~prev;

endmodule

// File: rtl/cp0_exc_sequencer.sv
// Exception/eret sequencer between the single-cycle datapath and CP0:
// prioritises traps/eret/interrupt, strobes CP0 and redirects the PC.
module cp0_exc_sequencer
    import cp0_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [4:0] C_INT       = CAUSE_INT,
    parameter logic [4:0] C_SYSCALL   = CAUSE_SYSCALL,
    parameter logic [4:0] C_BREAK     = CAUSE_BREAK,
    parameter logic [4:0] C_TEQ       = CAUSE_TEQ
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic        syscall_req,
    input  logic        break_req,
    input  logic        teq_req,
    input  logic        eret_req,
    input  logic        intr,
    input  logic [31:0] status,
    input  logic [31:0] exc_addr,
    input  logic [31:0] ret_addr,
    output logic        cp0_exception,
    output logic        cp0_eret,
    output logic [4:0]  cp0_cause,
    output logic [31:0] cp0_pc,
    output logic        stall,
    output logic        pc_redirect,
    output logic [31:0] redirect_addr,
    output logic        busy
);

    state_t     state;
    logic       int_pend;
    logic       irq_pulse;
    logic       stall_q;
    logic       take_exc;
    logic       take_eret;
    logic [4:0] take_cause;
    logic       sys_ok;
    logic       brk_ok;
    logic       teq_ok;
    logic       irq_ok;
    logic       unused_status;

    assign unused_status = ^{status[31:9], status[7:4]};

    cp0_irq_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .intr  (intr),
        .pulse (irq_pulse)
    );

    assign sys_ok = syscall_req & status[ST_IE] & status[ST_SYS];
    assign brk_ok = break_req & status[ST_IE] & status[ST_BRK];
    assign teq_ok = teq_req & status[ST_IE] & status[ST_TEQ];
    assign irq_ok = int_pend & status[ST_IE] & status[ST_INT];

    // Priority pick of the request to take; only sampled in IDLE
    always_comb begin
        take_exc   = 1'b0;
        take_eret  = 1'b0;
        take_cause = C_INT;
        if (state == IDLE && id_valid) begin
            priority case (1'b1)
                sys_ok: begin
                    take_exc   = 1'b1;
                    take_cause = C_SYSCALL;
                end
                brk_ok: begin
                    take_exc   = 1'b1;
                    take_cause = C_BREAK;
                end
                teq_ok: begin
                    take_exc   = 1'b1;
                    take_cause = C_TEQ;
                end
                eret_req: begin
                    take_eret  = 1'b1;
                end
                irq_ok: begin
                    take_exc   = 1'b1;
                    take_cause = C_INT;
                end
                default: begin
                end
            endcase
        end
    end

    // Pending interrupt: a new edge wins over the clear of a taken one
    always_ff @(posedge clk) begin
        if (!rst) begin
            int_pend <= 1'b0;
        end else if (irq_pulse) begin
            int_pend <= 1'b1;
        end else if (state == EXC_ENTER && cp0_cause == C_INT) begin
            int_pend <= 1'b0;
        end
    end

    // Sequencer FSM with registered strobes, cause and pc
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            cp0_exception <= 1'b0;
            cp0_eret      <= 1'b0;
            cp0_cause     <= '0;
            cp0_pc        <= '0;
            pc_redirect   <= 1'b0;
            stall_q       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (take_exc) begin
                        state         <= EXC_ENTER;
                        cp0_exception <= 1'b1;
                        cp0_cause     <= take_cause;
                        cp0_pc        <= id_pc;
                        stall_q       <= 1'b1;
                    end else if (take_eret) begin
                        state    <= RET_ENTER;
                        cp0_eret <= 1'b1;
                        stall_q  <= 1'b1;
                    end
                end
                EXC_ENTER: begin
                    state         <= EXC_REDIR;
                    cp0_exception <= 1'b0;
                    cp0_cause     <= '0;
                    cp0_pc        <= '0;
                    pc_redirect   <= 1'b1;
                end
                EXC_REDIR: begin
                    state       <= IDLE;
                    pc_redirect <= 1'b0;
                    stall_q     <= 1'b0;
                end
                RET_ENTER: begin
                    state       <= RET_REDIR;
                    cp0_eret    <= 1'b0;
                    pc_redirect <= 1'b1;
                end
                RET_REDIR: begin
                    state       <= IDLE;
                    pc_redirect <= 1'b0;
                    stall_q     <= 1'b0;
                end
                default: begin
                    state         <= IDLE;
                    cp0_exception <= 1'b0;
                    cp0_eret      <= 1'b0;
                    cp0_cause     <= '0;
                    cp0_pc        <= '0;
                    pc_redirect   <= 1'b0;
                    stall_q       <= 1'b0;
                end
            endcase
        end
    end

    // Redirect target follows the live CP0 vector/EPC in the redirect cycle
    always_comb begin
        redirect_addr = '0;
        if (pc_redirect) begin
            redirect_addr = (state == EXC_REDIR) ? exc_addr : ret_addr;
        end
    end

    assign stall = stall_q | take_exc | take_eret;
    assign busy  = (state != IDLE);

endmodule
